// File: rtl/fb_rx_pkg.sv
// Shared constants for the FREEDM-bus receive path: default frame geometry
// and bit positions inside the two-bit state vectors.
package fb_rx_pkg;

    // Default frame geometry
    localparam int FB_DATA_BYTES  = 4;
    localparam int FB_DELAY_BYTES = 2;
    localparam int FB_CRC_NIBBLES = 8;

    // The CRC nibble counter is fixed at 4 bits (up to 16 nibbles)
    localparam int FB_CRC_CNT_W   = 4;

    // Bit positions inside the two-bit Numb/Dist/Delay/Data state vectors
    localparam int FB_NIB_LO      = 0;
    localparam int FB_NIB_HI      = 1;

    // Which payload terminal value the byte counter compares against
    typedef enum logic [0:0] {
        FB_TERM_DELAY = 1'b0,
        FB_TERM_DATA  = 1'b1
    } fb_term_e;

    // True when either nibble of a two-bit state vector is active
    function automatic logic fb_nib_any(input logic [1:0] s);
        return s[FB_NIB_LO] | s[FB_NIB_HI];
    endfunction

endpackage

// File: rtl/fb_rx_termcnt.sv
// Synchronous up-counter with clear, enable and load-zero, plus a compare
// against a run-time terminal value. Increments that would pass the terminal
// value return to zero instead of wrapping through the whole range.
module fb_rx_termcnt
    import fb_rx_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic         i_ld0,
    input  logic [W-1:0] i_term,
    output logic [W-1:0] o_cnt,
    output logic         o_at_term
);

    logic [W-1:0] r_cnt;
    logic         w_at_term;

    assign w_at_term = (r_cnt == i_term);
    assign o_cnt     = r_cnt;
    assign o_at_term = w_at_term;

    // Count register: clear beats load-zero, load-zero beats increment
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_ld0) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_at_term ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fb_rxcounters.sv
// FREEDM-bus RX counters: byte and CRC-nibble counting, combinational
// frame-end qualifiers for the RX state machine, and truncation flagging.
// Optional frame-length watchdog enabled by defining FB_RXCNT_MAXLEN_EN.
module fb_rxcounters
    import fb_rx_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DATA_BYTES  = FB_DATA_BYTES,
    parameter int DELAY_BYTES = FB_DELAY_BYTES,
    parameter int CRC_NIBBLES = FB_CRC_NIBBLES,
    parameter int MAX_NIBBLES = 64
) (
    input  logic             MRxClk,
    input  logic             Reset,
    input  logic             MRxDV,
    input  logic             StateIdle,
    input  logic             StatePreamble,
    input  logic [1:0]       StateNumb,
    input  logic [1:0]       StateDist,
    input  logic [1:0]       StateDelay,
    input  logic [1:0]       StateData,
    input  logic             StateFrmCrc,
    output logic             DataFrameEnd,
    output logic             DelayFrameEnd,
    output logic             FrmCrcStateEnd,
    output logic [CNT_W-1:0] ByteCnt,
    output logic             RxAbort,
    output logic             FrameTooLong
);

    localparam int                CRC_W      = FB_CRC_CNT_W;
    localparam logic [CNT_W-1:0]  DATA_TERM  = CNT_W'(DATA_BYTES - 1);
    localparam logic [CNT_W-1:0]  DELAY_TERM = CNT_W'(DELAY_BYTES - 1);
    localparam logic [CRC_W-1:0]  CRC_TERM   = CRC_W'(CRC_NIBBLES - 1);

    logic             w_in_payload;
    logic             w_hi_nibble;
    fb_term_e         w_term_sel;
    logic [CNT_W-1:0] w_byte_term;
    logic             w_byte_at_term;
    logic [CRC_W-1:0] w_crc_cnt;
    logic             w_crc_at_term;
    logic             w_abort_cond;
    logic             r_rx_abort;
    logic             w_unused;

    // Payload decode: the byte counter only runs in Data/Delay and only
    // advances when a high nibble completes a byte.
    assign w_in_payload = fb_nib_any(StateData) | fb_nib_any(StateDelay);
    assign w_hi_nibble  = StateData[FB_NIB_HI] | StateDelay[FB_NIB_HI];
    assign w_term_sel   = fb_nib_any(StateData) ? FB_TERM_DATA : FB_TERM_DELAY;
    assign w_byte_term  = (w_term_sel == FB_TERM_DATA) ? DATA_TERM : DELAY_TERM;

    // Zero-latency end qualifiers so the state machine can leave in-cycle
    assign DataFrameEnd   = StateData[FB_NIB_HI]  & (ByteCnt == DATA_TERM);
    assign DelayFrameEnd  = StateDelay[FB_NIB_HI] & (ByteCnt == DELAY_TERM);
    assign FrmCrcStateEnd = StateFrmCrc & w_crc_at_term;

    fb_rx_termcnt #(
        .W (CNT_W)
    ) u_byte_cnt (
        .i_clk     (MRxClk),
        .i_rst     (Reset),
        .i_clr     (~w_in_payload),
        .i_en      (w_hi_nibble & MRxDV),
        .i_ld0     ((DataFrameEnd | DelayFrameEnd) & MRxDV),
        .i_term    (w_byte_term),
        .o_cnt     (ByteCnt),
        .o_at_term (w_byte_at_term)
    );

    // CRC nibbles are counted by time alone; MRxDV does not gate them
    fb_rx_termcnt #(
        .W (CRC_W)
    ) u_crc_cnt (
        .i_clk     (MRxClk),
        .i_rst     (Reset),
        .i_clr     (~StateFrmCrc),
        .i_en      (StateFrmCrc),
        .i_ld0     (FrmCrcStateEnd),
        .i_term    (CRC_TERM),
        .o_cnt     (w_crc_cnt),
        .o_at_term (w_crc_at_term)
    );

    // Carrier loss in states where the state machine has no abort path
    assign w_abort_cond = ~MRxDV & (fb_nib_any(StateNumb) | fb_nib_any(StateDist)
                                    | fb_nib_any(StateDelay));

    // Registered abort flag, high for as long as the loss persists
    always_ff @(posedge MRxClk) begin
        if (Reset) begin
            r_rx_abort <= 1'b0;
        end else begin
            r_rx_abort <= w_abort_cond;
        end
    end

    assign RxAbort = r_rx_abort;

`ifdef FB_RXCNT_MAXLEN_EN
    localparam int              NIB_W    = $clog2(MAX_NIBBLES) + 1;
    localparam logic [NIB_W-1:0] NIB_MAX  = NIB_W'(MAX_NIBBLES);
    localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(MAX_NIBBLES - 1);

    logic [NIB_W-1:0] r_nib_cnt;
    logic             r_too_long;

    // Frame-length watchdog: saturating nibble count, sticky flag set on
    // the edge that completes nibble MAX_NIBBLES, both cleared in Idle
    always_ff @(posedge MRxClk) begin
        if (Reset || StateIdle) begin
            r_nib_cnt  <= '0;
            r_too_long <= 1'b0;
        end else begin
            if (r_nib_cnt != NIB_MAX) begin
                r_nib_cnt <= r_nib_cnt + 1'b1;
            end
            if (r_nib_cnt == NIB_LAST) begin
                r_too_long <= 1'b1;
            end
        end
    end

    assign FrameTooLong = r_too_long;
    assign w_unused     = ^{StatePreamble, w_byte_at_term, w_crc_cnt};
`else
    assign FrameTooLong = 1'b0;
    assign w_unused     = ^{StatePreamble, StateIdle, w_byte_at_term, w_crc_cnt,
                            32'(MAX_NIBBLES)};
`endif

endmodule

// File: tb/tb_fb_rxcounters.sv
// Bench for fb_rxcounters: directed frames with literal expectations, then
// randomized frames checked every cycle against a behavioural model.
// Define FB_RXCNT_MAXLEN_EN here too when building the watchdog variant.
module tb_fb_rxcounters;

    localparam int CNT_W = 8;
    localparam int DB    = 4;
    localparam int LB    = 2;
    localparam int CN    = 8;
    localparam int MN    = 16;

    localparam int S_IDLE = 0, S_PRE = 1, S_NUMB = 2, S_DIST = 3,
                   S_DELAY = 4, S_DATA = 5, S_CRC = 6;

    logic             clk = 1'b0;
    logic             Reset = 1'b1;
    logic             MRxDV = 1'b0;
    logic             StateIdle = 1'b1;
    logic             StatePreamble = 1'b0;
    logic [1:0]       StateNumb = 2'b00;
    logic [1:0]       StateDist = 2'b00;
    logic [1:0]       StateDelay = 2'b00;
    logic [1:0]       StateData = 2'b00;
    logic             StateFrmCrc = 1'b0;
    logic             DataFrameEnd, DelayFrameEnd, FrmCrcStateEnd;
    logic [CNT_W-1:0] ByteCnt;
    logic             RxAbort, FrameTooLong;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_on   = 1'b0;

    always #5 clk = ~clk;

    fb_rxcounters #(
        .CNT_W       (CNT_W),
        .DATA_BYTES  (DB),
        .DELAY_BYTES (LB),
        .CRC_NIBBLES (CN),
        .MAX_NIBBLES (MN)
    ) dut (
        .MRxClk         (clk),
        .Reset          (Reset),
        .MRxDV          (MRxDV),
        .StateIdle      (StateIdle),
        .StatePreamble  (StatePreamble),
        .StateNumb      (StateNumb),
        .StateDist      (StateDist),
        .StateDelay     (StateDelay),
        .StateData      (StateData),
        .StateFrmCrc    (StateFrmCrc),
        .DataFrameEnd   (DataFrameEnd),
        .DelayFrameEnd  (DelayFrameEnd),
        .FrmCrcStateEnd (FrmCrcStateEnd),
        .ByteCnt        (ByteCnt),
        .RxAbort        (RxAbort),
        .FrameTooLong   (FrameTooLong)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: byte index within the payload, length of the current
    // run of CRC cycles, last-cycle carrier loss, and non-idle run length.
    int m_byte  = 0;
    int m_crc   = 0;
    bit m_abort = 1'b0;
    int m_nib   = 0;
    bit m_ftl   = 1'b0;

    always @(posedge clk) begin
        if (Reset) begin
            m_byte  <= 0;
            m_crc   <= 0;
            m_abort <= 1'b0;
            m_nib   <= 0;
            m_ftl   <= 1'b0;
        end else begin
            if (StateData == 2'b00 && StateDelay == 2'b00)
                m_byte <= 0;
            else if ((StateData[1] || StateDelay[1]) && MRxDV)
                m_byte <= (m_byte + 1) % (StateData[1] ? DB : LB);
            m_crc   <= StateFrmCrc ? m_crc + 1 : 0;
            m_abort <= !MRxDV && (StateNumb != 0 || StateDist != 0 || StateDelay != 0);
            if (StateIdle) begin
                m_nib <= 0;
                m_ftl <= 1'b0;
            end else begin
                m_nib <= (m_nib < MN) ? m_nib + 1 : m_nib;
                m_ftl <= m_ftl || (m_nib + 1 >= MN);
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle
    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_bytecnt", 32'(ByteCnt), 32'(m_byte));
            chk("model_dataend", 32'(DataFrameEnd), 32'(StateData[1] && m_byte == DB - 1));
            chk("model_delayend", 32'(DelayFrameEnd), 32'(StateDelay[1] && m_byte == LB - 1));
            chk("model_crcend", 32'(FrmCrcStateEnd), 32'(StateFrmCrc && (m_crc % CN) == CN - 1));
            chk("model_rxabort", 32'(RxAbort), 32'(m_abort));
`ifdef FB_RXCNT_MAXLEN_EN
            chk("model_toolong", 32'(FrameTooLong), 32'(m_ftl));
`else
            chk("model_toolong", 32'(FrameTooLong), 32'd0);
`endif
        end
    end

    // Advance one cycle with the given state, then return at mid-cycle
    task automatic put(input int st, input int hi, input logic dv, input logic rst);
        @(posedge clk);
        #1;
        Reset         = rst;
        MRxDV         = dv;
        StateIdle     = (st == S_IDLE);
        StatePreamble = (st == S_PRE);
        StateNumb     = (st == S_NUMB)  ? (hi != 0 ? 2'b10 : 2'b01) : 2'b00;
        StateDist     = (st == S_DIST)  ? (hi != 0 ? 2'b10 : 2'b01) : 2'b00;
        StateDelay    = (st == S_DELAY) ? (hi != 0 ? 2'b10 : 2'b01) : 2'b00;
        StateData     = (st == S_DATA)  ? (hi != 0 ? 2'b10 : 2'b01) : 2'b00;
        StateFrmCrc   = (st == S_CRC);
        @(negedge clk);
    endtask

    task automatic header();
        put(S_PRE, 0, 1'b1, 1'b0);
        put(S_NUMB, 0, 1'b1, 1'b0);
        put(S_NUMB, 1, 1'b1, 1'b0);
        put(S_DIST, 0, 1'b1, 1'b0);
        put(S_DIST, 1, 1'b1, 1'b0);
    endtask

    function automatic logic rnd_rst();
        return ($urandom_range(0, 149) == 0);
    endfunction

    // Nibble that the state machine retries until the carrier is present
    task automatic retry_nib(input int st, input int hi);
        logic dv;
        int   tries = 0;
        do begin
            dv = ($urandom_range(0, 7) != 0) || (tries >= 6);
            put(st, hi, dv, rnd_rst());
            tries++;
        end while (!dv);
    endtask

    initial begin
        // Reset
        put(S_IDLE, 0, 1'b1, 1'b1);
        put(S_IDLE, 0, 1'b1, 1'b1);
        chk("rst_bytecnt", 32'(ByteCnt), 32'd0);
        chk("rst_rxabort", 32'(RxAbort), 32'd0);
        chk("rst_toolong", 32'(FrameTooLong), 32'd0);
        chk_on = 1'b1;
        put(S_IDLE, 0, 1'b1, 1'b0);

        // Data frame: end on 8th nibble only, ByteCnt 0,0,1,1,2,2,3,3
        header();
        for (int k = 0; k < 2 * DB; k++) begin
            put(S_DATA, k % 2, 1'b1, 1'b0);
            chk("data_end", 32'(DataFrameEnd), 32'(k == 2 * DB - 1));
            chk("data_byte", 32'(ByteCnt), 32'(k / 2));
        end
        // CRC with carrier absent: end on exactly the 8th cycle
        for (int j = 0; j < CN; j++) begin
            put(S_CRC, 0, 1'b0, 1'b0);
            if (j == 0) chk("crc_first_byte", 32'(ByteCnt), 32'd0);
            chk("crc_end", 32'(FrmCrcStateEnd), 32'(j == CN - 1));
        end
        put(S_IDLE, 0, 1'b1, 1'b0);

        // Delay frame: ByteCnt 0,0,1,1 then 0, end on 4th nibble only
        header();
        for (int k = 0; k < 2 * LB; k++) begin
            put(S_DELAY, k % 2, 1'b1, 1'b0);
            chk("delay_end", 32'(DelayFrameEnd), 32'(k == 2 * LB - 1));
            chk("delay_byte", 32'(ByteCnt), 32'(k / 2));
        end
        put(S_CRC, 0, 1'b1, 1'b0);
        chk("delay_after_byte", 32'(ByteCnt), 32'd0);
        for (int j = 1; j < CN; j++) put(S_CRC, 0, 1'b1, 1'b0);
        put(S_IDLE, 0, 1'b1, 1'b0);

        // Carrier lost in Dist[0]: abort one cycle later, held while lost
        put(S_PRE, 0, 1'b1, 1'b0);
        put(S_NUMB, 0, 1'b1, 1'b0);
        put(S_NUMB, 1, 1'b1, 1'b0);
        put(S_DIST, 0, 1'b0, 1'b0);
        chk("abort_same_cycle", 32'(RxAbort), 32'd0);
        put(S_DIST, 0, 1'b0, 1'b0);
        chk("abort_next", 32'(RxAbort), 32'd1);
        put(S_DIST, 0, 1'b0, 1'b0);
        chk("abort_held", 32'(RxAbort), 32'd1);
        put(S_DIST, 0, 1'b1, 1'b0);
        chk("abort_last", 32'(RxAbort), 32'd1);
        put(S_DIST, 1, 1'b1, 1'b0);
        chk("abort_cleared", 32'(RxAbort), 32'd0);

        // Carrier lost in Data: no abort, ByteCnt 0 a cycle after Idle
        put(S_DATA, 0, 1'b1, 1'b0);
        put(S_DATA, 1, 1'b1, 1'b0);
        put(S_DATA, 0, 1'b0, 1'b0);
        put(S_IDLE, 0, 1'b0, 1'b0);
        chk("drop_abort", 32'(RxAbort), 32'd0);
        chk("drop_byte_held", 32'(ByteCnt), 32'd1);
        put(S_IDLE, 0, 1'b0, 1'b0);
        chk("drop_byte_zero", 32'(ByteCnt), 32'd0);

        // Reset with ByteCnt=2 mid-data
        header();
        for (int k = 0; k < 4; k++) put(S_DATA, k % 2, 1'b1, 1'b0);
        put(S_DATA, 0, 1'b1, 1'b0);
        chk("pre_rst_byte", 32'(ByteCnt), 32'd2);
        put(S_DATA, 1, 1'b1, 1'b1);
        put(S_DATA, 1, 1'b1, 1'b0);
        chk("midrst_byte", 32'(ByteCnt), 32'd0);
        chk("midrst_abort", 32'(RxAbort), 32'd0);
        chk("midrst_dataend", 32'(DataFrameEnd), 32'd0);
        put(S_IDLE, 0, 1'b1, 1'b0);

        // 20-nibble non-idle stream for the watchdog
        for (int i = 1; i <= 20; i++) begin
            put(S_PRE, 0, 1'b1, 1'b0);
`ifdef FB_RXCNT_MAXLEN_EN
            chk("toolong_stream", 32'(FrameTooLong), 32'(i > MN));
`else
            chk("toolong_stream", 32'(FrameTooLong), 32'd0);
`endif
        end
        put(S_IDLE, 0, 1'b1, 1'b0);
        put(S_IDLE, 0, 1'b1, 1'b0);
        chk("toolong_idle", 32'(FrameTooLong), 32'd0);

        // Randomized frames with occasional carrier loss and resets
        for (int f = 0; f < 250; f++) begin
            int  n_idle;
            int  n_pre;
            bit  is_data;
            bit  dropped;
            logic dv;
            n_idle = $urandom_range(1, 3);
            n_pre  = $urandom_range(1, 2);
            for (int i = 0; i < n_idle; i++) put(S_IDLE, 0, 1'($urandom_range(0, 1)), rnd_rst());
            for (int i = 0; i < n_pre; i++) put(S_PRE, 0, 1'b1, rnd_rst());
            retry_nib(S_NUMB, 0);
            retry_nib(S_NUMB, 1);
            retry_nib(S_DIST, 0);
            retry_nib(S_DIST, 1);
            is_data = 1'($urandom_range(0, 1));
            dropped = 1'b0;
            if (is_data) begin
                for (int n = 0; n < 2 * DB && !dropped; n++) begin
                    dv = ($urandom_range(0, 15) != 0);
                    put(S_DATA, n % 2, dv, rnd_rst());
                    if (!dv) dropped = 1'b1;
                end
            end else begin
                for (int n = 0; n < 2 * LB; n++) retry_nib(S_DELAY, n % 2);
            end
            if (!dropped) begin
                for (int j = 0; j < CN; j++) put(S_CRC, 0, 1'($urandom_range(0, 1)), rnd_rst());
            end
        end
        put(S_IDLE, 0, 1'b1, 1'b0);
        put(S_IDLE, 0, 1'b1, 1'b0);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
